// File: rtl/wb_pkg.sv
// Shared constants and payload types for the writeback arbiter.
package wb_pkg;

  localparam int unsigned WB_NUM_SRC    = 4;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                     en;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Cyclic first-one finder: returns the first set bit of req_i at or after start_i, wrapping.
module wb_rr_pick
  import wb_pkg::*;
#(
  parameter int unsigned N  = WB_NUM_SRC,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int unsigned j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(start_i) + k) % N;
      if (!found_o && req_i[IW'(j)]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Round-robin writeback arbiter feeding two register-file write ports without same-cycle WAW.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = WB_NUM_SRC,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   src_valid_i,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]                   src_ready_o,
  input  logic                                 wb_stall_i,
  output logic                                 wr1_en_o,
  output logic [ADDR_WIDTH-1:0]                wr1_addr_o,
  output logic [DATA_WIDTH-1:0]                wr1_data_o,
  output logic                                 wr2_en_o,
  output logic [ADDR_WIDTH-1:0]                wr2_addr_o,
  output logic [DATA_WIDTH-1:0]                wr2_data_o
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    req_nz;
  logic [NUM_SRC-1:0]    sink;
  logic [NUM_SRC-1:0]    mask2;
  logic                  found1, found2;
  logic [IdxW-1:0]       idx1, idx2;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  grant1, grant2;

  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
  logic [ADDR_WIDTH-1:0] wr1_addr_q, wr1_addr_d, wr2_addr_q, wr2_addr_d;
  logic [DATA_WIDTH-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;

  function automatic logic [IdxW-1:0] ptr_after(input logic [IdxW-1:0] idx);
    return (32'(idx) == NUM_SRC - 1) ? '0 : idx + IdxW'(1);
  endfunction

  // Addr-0 requests are discarded sinks; only nonzero addresses compete for ports.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_nz[i] = src_valid_i[i] && (src_addr_i[i] != '0);
      sink[i]   = src_valid_i[i] && (src_addr_i[i] == '0);
    end
  end

  wb_rr_pick #(.N(NUM_SRC), .IW(IdxW)) u_pick1 (
    .req_i   (req_nz),
    .start_i (rr_ptr_q),
    .found_o (found1),
    .idx_o   (idx1)
  );

  assign addr1 = src_addr_i[idx1];

  // Clearing every request matching the port-1 address also removes the port-1 winner.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      mask2[i] = found1 && req_nz[i] && (src_addr_i[i] != addr1);
    end
  end

  wb_rr_pick #(.N(NUM_SRC), .IW(IdxW)) u_pick2 (
    .req_i   (mask2),
    .start_i (rr_ptr_q),
    .found_o (found2),
    .idx_o   (idx2)
  );

  assign grant1 = found1 && !wb_stall_i;
  assign grant2 = found2 && !wb_stall_i;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready_o[i] = rst_n && !wb_stall_i &&
                       (sink[i] || (found1 && (idx1 == IdxW'(i))) ||
                        (found2 && (idx2 == IdxW'(i))));
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr1_en_d   = grant1;
    wr1_addr_d = wr1_addr_q;
    wr1_data_d = wr1_data_q;
    wr2_en_d   = grant2;
    wr2_addr_d = wr2_addr_q;
    wr2_data_d = wr2_data_q;
    if (grant1) begin
      wr1_addr_d = src_addr_i[idx1];
      wr1_data_d = src_data_i[idx1];
      rr_ptr_d   = ptr_after(idx1);
    end
    if (grant2) begin
      wr2_addr_d = src_addr_i[idx2];
      wr2_data_d = src_data_i[idx2];
      rr_ptr_d   = ptr_after(idx2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      wr1_en_q   <= 1'b0;
      wr1_addr_q <= '0;
      wr1_data_q <= '0;
      wr2_en_q   <= 1'b0;
      wr2_addr_q <= '0;
      wr2_data_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr1_en_q   <= wr1_en_d;
      wr1_addr_q <= wr1_addr_d;
      wr1_data_q <= wr1_data_d;
      wr2_en_q   <= wr2_en_d;
      wr2_addr_q <= wr2_addr_d;
      wr2_data_q <= wr2_data_d;
    end
  end

  assign wr1_en_o   = wr1_en_q;
  assign wr1_addr_o = wr1_addr_q;
  assign wr1_data_o = wr1_data_q;
  assign wr2_en_o   = wr2_en_q;
  assign wr2_addr_o = wr2_addr_q;
  assign wr2_data_o = wr2_data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter with hand-computed expectations.
module tb_wb_write_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic                   clk;
  logic                   rst_n;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0][AW-1:0]  src_addr;
  logic [NS-1:0][DW-1:0]  src_data;
  logic [NS-1:0]          src_ready;
  logic                   stall;
  logic                   wr1_en, wr2_en;
  logic [AW-1:0]          wr1_addr, wr2_addr;
  logic [DW-1:0]          wr1_data, wr2_data;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] DA = 32'hAAAA_0001;
  localparam logic [DW-1:0] DB = 32'hBBBB_0002;
  localparam logic [DW-1:0] DC = 32'hCCCC_0003;
  localparam logic [DW-1:0] DD = 32'hDDDD_0004;

  wb_write_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid_i (src_valid),
    .src_addr_i  (src_addr),
    .src_data_i  (src_data),
    .src_ready_o (src_ready),
    .wb_stall_i  (stall),
    .wr1_en_o    (wr1_en),
    .wr1_addr_o  (wr1_addr),
    .wr1_data_o  (wr1_data),
    .wr2_en_o    (wr2_en),
    .wr2_addr_o  (wr2_addr),
    .wr2_data_o  (wr2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag,
                          input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic e2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    check({tag, ".en1"},   64'(wr1_en),   64'(e1));
    check({tag, ".addr1"}, 64'(wr1_addr), 64'(a1));
    check({tag, ".data1"}, 64'(wr1_data), 64'(d1));
    check({tag, ".en2"},   64'(wr2_en),   64'(e2));
    check({tag, ".addr2"}, 64'(wr2_addr), 64'(a2));
    check({tag, ".data2"}, 64'(wr2_data), 64'(d2));
  endtask

  task automatic load_abcd();
    src_addr[0] = 5'd1; src_data[0] = DA;
    src_addr[1] = 5'd2; src_data[1] = DB;
    src_addr[2] = 5'd3; src_data[2] = DC;
    src_addr[3] = 5'd4; src_data[3] = DD;
  endtask

  initial begin
    logic granted;
    rst_n     = 1'b0;
    stall     = 1'b0;
    src_valid = 4'b1111;
    load_abcd();
    #1;
    check_wr("reset", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("reset.ready", 64'(src_ready), 64'(4'b0000));
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Four distinct sources starting at pointer 0.
    check("rr.ready0", 64'(src_ready), 64'(4'b0011));
    tick();
    check_wr("rr.n1", 1'b1, 5'd1, DA, 1'b1, 5'd2, DB);
    src_valid = 4'b1100;
    #1;
    check("rr.ready1", 64'(src_ready), 64'(4'b1100));
    tick();
    check_wr("rr.n2", 1'b1, 5'd3, DC, 1'b1, 5'd4, DD);
    src_valid = 4'b0000;
    tick();
    check_wr("idle.hold", 1'b0, 5'd3, DC, 1'b0, 5'd4, DD);

    // Same destination on sources 0 and 1: only one port may take it.
    src_addr[0] = 5'd7; src_data[0] = 32'h11;
    src_addr[1] = 5'd7; src_data[1] = 32'h22;
    src_valid   = 4'b0011;
    #1;
    check("waw.ready0", 64'(src_ready), 64'(4'b0001));
    tick();
    check_wr("waw.n1", 1'b1, 5'd7, 32'h11, 1'b0, 5'd4, DD);
    src_valid = 4'b0010;
    #1;
    check("waw.ready1", 64'(src_ready), 64'(4'b0010));
    tick();
    check_wr("waw.n2", 1'b1, 5'd7, 32'h22, 1'b0, 5'd4, DD);

    // Address-0 sink on source 2; pointer must stay at 2.
    src_addr[2] = 5'd0; src_data[2] = 32'hDEAD;
    src_valid   = 4'b0100;
    #1;
    check("sink.ready", 64'(src_ready), 64'(4'b0100));
    tick();
    check_wr("sink.noen", 1'b0, 5'd7, 32'h22, 1'b0, 5'd4, DD);
    src_addr[0] = 5'd1; src_data[0] = 32'hA0;
    src_addr[2] = 5'd5; src_data[2] = 32'hC0;
    src_valid   = 4'b0101;
    #1;
    check("ptr.ready", 64'(src_ready), 64'(4'b0101));
    tick();
    check_wr("ptr.order", 1'b1, 5'd5, 32'hC0, 1'b1, 5'd1, 32'hA0);

    // Stall for 3 cycles right after a write cycle; pointer is now 1.
    load_abcd();
    src_valid = 4'b1111;
    stall     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall.ready", 64'(src_ready), 64'(4'b0000));
      tick();
      check_wr("stall.noen", 1'b0, 5'd5, 32'hC0, 1'b0, 5'd1, 32'hA0);
    end
    stall = 1'b0;
    #1;
    check("resume.ready0", 64'(src_ready), 64'(4'b0110));
    tick();
    check_wr("resume.n1", 1'b1, 5'd2, DB, 1'b1, 5'd3, DC);
    src_valid = 4'b1001;
    #1;
    check("resume.ready1", 64'(src_ready), 64'(4'b1001));
    tick();
    check_wr("resume.n2", 1'b1, 5'd4, DD, 1'b1, 5'd1, DA);

    // Sources 0 and 3 continuously valid: both granted every cycle.
    for (int c = 0; c < 3; c++) begin
      check("fair.ready", 64'(src_ready), 64'(4'b1001));
      tick();
      check_wr("fair.both", 1'b1, 5'd4, DD, 1'b1, 5'd1, DA);
    end

    // Source 3 arrives competing for the same register as a busy source 0.
    src_addr[0] = 5'd9;
    src_addr[3] = 5'd9;
    src_valid   = 4'b0001;
    tick();
    src_valid = 4'b1001;
    granted   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (!granted && src_ready[3]) granted = 1'b1;
      tick();
      if (granted) src_valid[3] = 1'b0;
    end
    check("fair.bound", 64'(granted), 64'(1'b1));

    // Async reset in the middle of a burst.
    load_abcd();
    src_valid = 4'b1111;
    tick();
    check("burst.en1", 64'(wr1_en), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check_wr("midrst", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("midrst.ready", 64'(src_ready), 64'(4'b0000));
    tick();
    check_wr("midrst.hold", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel.ready", 64'(src_ready), 64'(4'b0011));
    tick();
    check_wr("rel.n1", 1'b1, 5'd1, DA, 1'b1, 5'd2, DB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
